sprite_drawer: RTL
==================

# sprite_drawer

Parametrised sprite rasteriser for the game's framebuffer path. On a start request it latches a base coordinate, a monochrome bitmap and a colour pair, then emits one framebuffer write per cycle, scanning SPRITE_W columns by SPRITE_H rows. It sits between the game-logic FSMs (alien, player, bullet) and the VGA adapter's pixel-write port. It generalises the fixed five-pixel alien row drawer with:
- arbitrary sprite size;
- per-pixel masking;
- erase mode;
- stall back-pressure;
- a start/done handshake.

## Interface
- SPRITE_W, default 5: columns per sprite row, 1..16
- SPRITE_H, default 4: rows per sprite, 1..16
- X_W, default 8: x coordinate width
- Y_W, default 7: y coordinate width
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  draw request, sampled only in IDLE
- erase  in  1  latched with start; 1 = draw every pixel in colour_bg
- base_x  in  X_W  top-left x, latched with start
- base_y  in  Y_W  top-left y, latched with start
- bitmap  in  SPRITE_W*SPRITE_H  pixel mask, latched with start; bit (row*SPRITE_W+col), bit 0 = top-left
- colour_fg  in  3  colour for set bitmap bits
- colour_bg  in  3  colour for clear bits and for erase
- stall  in  1  framebuffer not ready; hold current pixel
- x  out  X_W  pixel x
- y  out  Y_W  pixel y
- colour  out  3  pixel colour
- write_en  out  1  pixel write strobe
- busy  out  1  high in DRAW and DONE
- done  out  1  one-cycle pulse after the last pixel

## Operation
- States:
  - IDLE: start=1 latches all inputs, sets col=0, row=0, goes to DRAW.
  - DRAW: presents pixel (col,row) each cycle.
  - DONE: done=1 for one cycle, then IDLE.
- DRAW advance, when stall=0: col increments. At col=SPRITE_W-1, col returns to 0 and row increments. At col=SPRITE_W-1 and row=SPRITE_H-1, next state is DONE.
- DRAW hold, when stall=1: col, row and state hold; write_en=0; x, y and colour still show the held pixel.
- x = base_x_q + col, truncated to X_W; it wraps modulo 2^X_W. y = base_y_q + row, truncated to Y_W; it wraps the same way. No clipping.
- Pixel colour:
  - erase_q=1: colour_bg_q.
  - Otherwise: colour_fg_q if the bitmap bit is 1, else colour_bg_q.
- write_en = 1 in DRAW when stall=0, subject to the mask rule in Configuration.
- start outside IDLE is ignored. There is no queueing.
- colour_fg, colour_bg, base and bitmap changes after acceptance have no effect until the next accepted start.
- Reset takes precedence over everything, including mid-draw. The next state is IDLE.
- Reset values:
  - x=0, y=0, colour=0, write_en=0, busy=0, done=0
  - col/row counters and latched registers = 0

## Timing
- Start sampled high in IDLE at edge N: first pixel (0,0) is valid during cycle N+1.
- Unstalled draw: exactly SPRITE_W*SPRITE_H DRAW cycles. Each stall cycle adds one.
- done is high the cycle after the last DRAW cycle. The earliest next start is accepted the cycle after done, because the block is then in IDLE.
- Back-to-back draws cost SPRITE_W*SPRITE_H+2 cycles each.
- Outputs derive from registered state and latched data. The only combinational paths are stall to write_en and stall to next-state.

## Configuration
- SPRITE_TRANSPARENT_EN defined: in non-erase mode, pixels whose bitmap bit is 0 get write_en=0. The cycle is still consumed, so timing is unchanged. The background under the sprite is preserved.
- SPRITE_TRANSPARENT_EN undefined: every pixel is written. Clear bits use colour_bg.
- Erase mode writes every pixel regardless of the macro.

## Structure
- Package sprite_pkg holds:
  - state enum (IDLE, DRAW, DONE);
  - COLOUR_W = 3;
  - colour constants (BLACK = 3'b000, MAGENTA = 3'b101, WHITE = 3'b111).
- One sub-module, sprite_scan_counter. It is the col/row raster counter with parameters SPRITE_W and SPRITE_H. Its ports are clk, reset, clear, advance, col, row and last.
- sprite_drawer owns the FSM, the latch registers, the adders and the colour/mask mux.

## Test plan
- Defaults, bitmap=20'hFFFFF, base (10,20), fg=3'b101, start one cycle, stall=0:
  - 20 writes at x=10..14, y=20..23, raster order, colour 3'b101;
  - done exactly 21 cycles after start.
- bitmap=20'h00001, fg=3'b101, bg=3'b000, macro undefined:
  - pixel (10,20) is 3'b101;
  - the other 19 are 3'b000.
- Same stimulus with SPRITE_TRANSPARENT_EN defined: exactly one write_en pulse, at cycle N+1. done is still at N+21.
- Stall held for 3 cycles at pixel 7: write_en=0 and x/y frozen for those cycles; done is delayed to N+24; no pixel is skipped or duplicated.
- base_x=8'd254, SPRITE_W=5: x sequence is 254, 255, 0, 1, 2.
- Reset asserted at pixel 9, with start high during DRAW: after reset, all outputs are 0 and the state is IDLE. The start during DRAW is ignored. A fresh start redraws from (0,0).

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite rasteriser.
package sprite_pkg;
  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  localparam int COLOUR_W = 3;

  localparam logic [COLOUR_W-1:0] BLACK   = 3'b000;
  localparam logic [COLOUR_W-1:0] MAGENTA = 3'b101;
  localparam logic [COLOUR_W-1:0] WHITE   = 3'b111;
endpackage

// File: rtl/sprite_scan_counter.sv
// Column/row raster counter; 'last' flags the bottom-right pixel of the sprite.
module sprite_scan_counter #(
  parameter int SPRITE_W = 5,
  parameter int SPRITE_H = 4,
  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1,
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last
);
  logic col_end, row_end;

  assign col_end = (col == CW'(SPRITE_W - 1));
  assign row_end = (row == RW'(SPRITE_H - 1));
  assign last    = col_end && row_end;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/sprite_drawer.sv
// Sprite rasteriser: latches a bitmap on start and emits one framebuffer write per cycle.
// Optional macro SPRITE_TRANSPARENT_EN suppresses writes of clear bitmap bits (non-erase).
module sprite_drawer
  import sprite_pkg::*;
#(
  parameter int SPRITE_W = 5,
  parameter int SPRITE_H = 4,
  parameter int X_W      = 8,
  parameter int Y_W      = 7
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         erase,
  input  logic [X_W-1:0]               base_x,
  input  logic [Y_W-1:0]               base_y,
  input  logic [SPRITE_W*SPRITE_H-1:0] bitmap,
  input  logic [COLOUR_W-1:0]          colour_fg,
  input  logic [COLOUR_W-1:0]          colour_bg,
  input  logic                         stall,
  output logic [X_W-1:0]               x,
  output logic [Y_W-1:0]               y,
  output logic [COLOUR_W-1:0]          colour,
  output logic                         write_en,
  output logic                         busy,
  output logic                         done
);
  localparam int NPIX = SPRITE_W * SPRITE_H;
  localparam int CW   = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW   = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int IW   = $clog2(NPIX + 1);

  state_t                state;
  logic [X_W-1:0]        base_x_q;
  logic [Y_W-1:0]        base_y_q;
  logic [NPIX-1:0]       bitmap_q, bitmap_sh;
  logic [COLOUR_W-1:0]   fg_q, bg_q;
  logic                  erase_q;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic                  last, accept, advance, pix_bit, mask;
  logic [IW-1:0]         pix_idx;

  assign accept  = (state == IDLE) && start;
  assign advance = (state == DRAW) && !stall;

  sprite_scan_counter #(.SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H)) u_scan (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .advance (advance),
    .col     (col),
    .row     (row),
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      base_x_q <= '0;
      base_y_q <= '0;
      bitmap_q <= '0;
      fg_q     <= BLACK;
      bg_q     <= BLACK;
      erase_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          state    <= DRAW;
          base_x_q <= base_x;
          base_y_q <= base_y;
          bitmap_q <= bitmap;
          fg_q     <= colour_fg;
          bg_q     <= colour_bg;
          erase_q  <= erase;
        end
        DRAW:    if (!stall && last) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Shift rather than index so the select stays width-clean for any sprite size.
  assign pix_idx   = IW'(row) * IW'(SPRITE_W) + IW'(col);
  assign bitmap_sh = bitmap_q >> pix_idx;
  assign pix_bit   = bitmap_sh[0];

`ifdef SPRITE_TRANSPARENT_EN
  assign mask = erase_q || pix_bit;
`else
  assign mask = 1'b1;
`endif

  assign x        = base_x_q + X_W'(col);
  assign y        = base_y_q + Y_W'(row);
  assign colour   = (erase_q || !pix_bit) ? bg_q : fg_q;
  assign write_en = advance && mask;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
endmodule
